// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding, register-file
// constants and the control word loaded into a stage on flush.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MSTALL = 1'b1
  } ctrl_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int unsigned STALL_LEN_W = 12;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       branch;
    logic       aluSrc;
    logic [1:0] aluOp;
  } ctrl_word_t;

  // A flushed stage register loads this word so the bubble has no side effects.
  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_cnt.sv
// Saturating event counter with a synchronous clear that wins over increment.
module sat_cnt
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: combinational per-stage
// strobes, memory-stall FSM, stall watchdog and saturating perf counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             branch_taken,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             ctrl_state,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_flush
);

  localparam logic [STALL_LEN_W-1:0] TIMEOUT_L = STALL_LEN_W'(TIMEOUT);

  ctrl_state_e            state;
  logic [STALL_LEN_W-1:0] stallLen;
  logic [STALL_LEN_W-1:0] stallLenNext;
  logic                   cacheStall;
  logic                   loadUse;
  logic                   bubbleInc;
  logic                   flushInc;

  assign cacheStall = icache_stall | dcache_stall;

  assign loadUse = ex_mem_read && (ex_rt != REG_ZERO) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // While frozen, branch and hazard inputs are re-presented after release,
  // so they are neither acted on nor counted during a cache stall.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst || cacheStall) begin
      // everything held
    end else if (loadUse) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      ifid_flush = branch_taken;
    end
  end

  assign bubbleInc = !cacheStall && loadUse;
  assign flushInc  = !cacheStall && !loadUse && branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_RUN;
    end else begin
      state <= cacheStall ? ST_MSTALL : ST_RUN;
    end
  end

  assign ctrl_state = (state == ST_MSTALL);

  assign stallLenNext = (stallLen == '1) ? stallLen : stallLen + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallLen      <= '0;
      stall_timeout <= 1'b0;
    end else if (perf_clr) begin
      stallLen      <= '0;
      stall_timeout <= 1'b0;
    end else if (cacheStall) begin
      stallLen <= stallLenNext;
      if (stallLenNext >= TIMEOUT_L) begin
        stall_timeout <= 1'b1;
      end
    end else begin
      stallLen <= '0;
    end
  end

  sat_cnt #(.W(CNT_W)) uStallCnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (cacheStall),
    .q   (perf_stall)
  );

  sat_cnt #(.W(CNT_W)) uBubbleCnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (bubbleInc),
    .q   (perf_bubble)
  );

  sat_cnt #(.W(CNT_W)) uFlushCnt (
    .clk (clk),
    .rst (rst),
    .clr (perf_clr),
    .inc (flushInc),
    .q   (perf_flush)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with small counters and a short watchdog.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             icache_stall, dcache_stall, ex_mem_read, id_uses_rt;
  logic             branch_taken, perf_clr;
  logic [4:0]       ex_rt, id_rs, id_rt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, ctrl_state, stall_timeout;
  logic [CNT_W-1:0] perf_stall, perf_bubble, perf_flush;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] S_RUN    = 7'b1111100;
  localparam logic [6:0] S_BRANCH = 7'b1111110;
  localparam logic [6:0] S_HAZARD = 7'b0011101;
  localparam logic [6:0] S_FROZEN = 7'b0000000;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .icache_stall  (icache_stall),
    .dcache_stall  (dcache_stall),
    .ex_mem_read   (ex_mem_read),
    .ex_rt         (ex_rt),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .branch_taken  (branch_taken),
    .perf_clr      (perf_clr),
    .pc_en         (pc_en),
    .ifid_en       (ifid_en),
    .idex_en       (idex_en),
    .exmem_en      (exmem_en),
    .memwb_en      (memwb_en),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .ctrl_state    (ctrl_state),
    .stall_timeout (stall_timeout),
    .perf_stall    (perf_stall),
    .perf_bubble   (perf_bubble),
    .perf_flush    (perf_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkStrobes(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {25'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush},
        {25'd0, exp});
  endtask

  task automatic chkRegs(input string tag, input logic st, input logic to,
                         input logic [CNT_W-1:0] ps, input logic [CNT_W-1:0] pb,
                         input logic [CNT_W-1:0] pf);
    chk(tag, {19'd0, ctrl_state, stall_timeout, perf_stall, perf_bubble, perf_flush},
        {19'd0, st, to, ps, pb, pf});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setHazard(input logic on);
    ex_mem_read = on;
    ex_rt       = on ? 5'd8 : 5'd0;
    id_rs       = on ? 5'd8 : 5'd0;
    id_rt       = 5'd0;
    id_uses_rt  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    icache_stall = 1'b0; dcache_stall = 1'b0; branch_taken = 1'b0; perf_clr = 1'b0;
    setHazard(1'b0);
    #2;
    chkStrobes("reset_strobes", S_FROZEN);
    chkRegs("reset_regs", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    cyc();
    rst = 1'b1;
    chkStrobes("idle", S_RUN);
    cyc();
    chkRegs("idle_regs", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

    // Load-use on rs
    setHazard(1'b1);
    chkStrobes("loaduse_rs", S_HAZARD);
    cyc();
    chkRegs("loaduse_cnt", 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

    // Destination r0 never creates a hazard
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    chkStrobes("zero_reg", S_RUN);
    cyc();
    chkRegs("zero_reg_cnt", 1'b0, 1'b0, 4'd0, 4'd1, 4'd0);

    // rt match only counts when rt is actually read
    ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd1; id_uses_rt = 1'b0;
    chkStrobes("rt_unused", S_RUN);
    id_uses_rt = 1'b1;
    chkStrobes("rt_used", S_HAZARD);
    cyc();
    chkRegs("rt_used_cnt", 1'b0, 1'b0, 4'd0, 4'd2, 4'd0);

    // Branch alone, then branch under hazard
    setHazard(1'b0);
    branch_taken = 1'b1;
    chkStrobes("branch", S_BRANCH);
    cyc();
    chkRegs("branch_cnt", 1'b0, 1'b0, 4'd0, 4'd2, 4'd1);
    setHazard(1'b1);
    chkStrobes("branch_hazard", S_HAZARD);
    cyc();
    chkRegs("branch_hazard_cnt", 1'b0, 1'b0, 4'd0, 4'd3, 4'd1);

    // D-cache stall for 4 cycles with branch and hazard held
    dcache_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chkStrobes($sformatf("dstall_strobes%0d", i), S_FROZEN);
      chk($sformatf("dstall_state%0d", i), {31'd0, ctrl_state}, (i == 0) ? 32'd0 : 32'd1);
      cyc();
    end
    chkRegs("dstall_regs", 1'b1, 1'b1, 4'd4, 4'd3, 4'd1);

    // Release with hazard present, clear coinciding with a bubble increment
    dcache_stall = 1'b0;
    perf_clr = 1'b1;
    chkStrobes("release_hazard", S_HAZARD);
    cyc();
    chkRegs("clr_wins", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    perf_clr = 1'b0; branch_taken = 1'b0;
    setHazard(1'b0);

    // Watchdog: 2-cycle episode, gap, 3-cycle episode (one cycle both caches)
    dcache_stall = 1'b1;
    cyc();
    cyc();
    chkRegs("wd_ep1", 1'b1, 1'b0, 4'd2, 4'd0, 4'd0);
    dcache_stall = 1'b0;
    cyc();
    chkRegs("wd_gap", 1'b0, 1'b0, 4'd2, 4'd0, 4'd0);
    icache_stall = 1'b1;
    cyc();
    chkRegs("wd_ep2_c1", 1'b1, 1'b0, 4'd3, 4'd0, 4'd0);
    dcache_stall = 1'b1;
    cyc();
    chkRegs("wd_ep2_c2_both", 1'b1, 1'b0, 4'd4, 4'd0, 4'd0);
    dcache_stall = 1'b0;
    cyc();
    chkRegs("wd_ep2_c3", 1'b1, 1'b1, 4'd5, 4'd0, 4'd0);
    icache_stall = 1'b0;
    cyc();
    chkRegs("wd_sticky", 1'b0, 1'b1, 4'd5, 4'd0, 4'd0);
    perf_clr = 1'b1;
    cyc();
    chkRegs("wd_clr", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    perf_clr = 1'b0;

    // Saturation of each counter
    setHazard(1'b1);
    for (int i = 0; i < 18; i++) cyc();
    chkRegs("sat_bubble", 1'b0, 1'b0, 4'd0, 4'd15, 4'd0);
    setHazard(1'b0);
    branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) cyc();
    chkRegs("sat_flush", 1'b0, 1'b0, 4'd0, 4'd15, 4'd15);
    branch_taken = 1'b0;
    icache_stall = 1'b1;
    for (int i = 0; i < 18; i++) cyc();
    chkRegs("sat_stall", 1'b1, 1'b1, 4'd15, 4'd15, 4'd15);

    // Asynchronous reset mid-stall, away from any clock edge
    #1;
    rst = 1'b0;
    #1;
    chkRegs("async_rst_regs", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    chkStrobes("async_rst_strobes", S_FROZEN);
    icache_stall = 1'b0;
    cyc();
    rst = 1'b1;
    chkStrobes("post_rst_run", S_RUN);
    cyc();
    chkRegs("post_rst_regs", 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
